// File: rtl/rca_4bit.sv
// Registered ripple-carry adder: {carry,sum} = a + b + cin with one-cycle latency.
// Optional macro RCA_OVERFLOW_EN adds a registered two's-complement overflow flag.
module rca_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             carry
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  // Full-adder cascade; each stage consumes the carry produced by the stage below it.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  // Result registers hold their value while in_valid is low; reset overrides a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
`ifdef RCA_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s;
        carry    <= c[WIDTH];
`ifdef RCA_OVERFLOW_EN
        overflow <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_rca_4bit.sv
// Self-checking bench for rca_4bit: scoreboard of expected {carry,sum} per accepted input.
// Overflow checks are compiled in when RCA_OVERFLOW_EN is defined.
module tb_rca_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry;
`ifdef RCA_OVERFLOW_EN
  logic         overflow;
`endif

  int checks;
  int failures;

  logic [W:0] scoreboard[$];

  rca_4bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
`ifdef RCA_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input beat; accepted beats (in_valid=1, rst=0) push their expected result.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic cv);
    logic [W:0] exp_val;
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
    exp_val  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    if (v && !r) scoreboard.push_back(exp_val);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || sum !== 4'h0 || carry !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset cycle %0d: out_valid=%b sum=%h carry=%b, required 0/0/0",
                 i, out_valid, sum, carry);
      end
    end
  endtask

  // Pop one scoreboard entry and compare against the registered outputs.
  task automatic check_result(input string name);
    logic [W:0] exp_val;
    checks++;
    if (scoreboard.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, out_valid=%b", name, out_valid);
    end else begin
      exp_val = scoreboard.pop_front();
      if (out_valid !== 1'b1 || {carry, sum} !== exp_val) begin
        failures++;
        $display("[TB] FAIL %s: out_valid=%b {carry,sum}=%h, required 1/%h",
                 name, out_valid, {carry, sum}, exp_val);
      end
    end
  endtask

  // Exhaustive sweep with in_valid held high, which is also the back-to-back case.
  task automatic test_exhaustive();
    int errs_before;
    errs_before = failures;
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          drive(1'b0, 1'b1, W'(x), W'(y), c[0]);
          check_result("exhaustive");
        end
    $display("[TB] exhaustive sweep: %0d new failures", failures - errs_before);
  endtask

  task automatic test_corners();
    drive(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
    check_result("corner_F_F_1");
    drive(1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    check_result("corner_wrap_F_0_1");
    drive(1'b0, 1'b1, 4'h7, 4'h8, 1'b0);
    check_result("corner_7_8_0");
    drive(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
    check_result("corner_zero");
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 4'h3, 4'h4, 1'b1);
    check_result("hold_load");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, W'(i + 9), 4'hE, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || sum !== 4'h8 || carry !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold cycle %0d: out_valid=%b sum=%h carry=%b, required 0/8/0",
                 i, out_valid, sum, carry);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 1'b1, 4'h5, 4'h6, 1'b0);
    check_result("midstream_pre");
    drive(1'b1, 1'b1, 4'h9, 4'h9, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || sum !== 4'h0 || carry !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midstream: out_valid=%b sum=%h carry=%b, required 0/0/0",
               out_valid, sum, carry);
    end
    drive(1'b0, 1'b1, 4'h9, 4'h9, 1'b0);
    check_result("midstream_post");
  endtask

`ifdef RCA_OVERFLOW_EN
  task automatic test_overflow();
    logic [W-1:0] av[3] = '{4'h7, 4'h8, 4'hF};
    logic [W-1:0] bv[3] = '{4'h1, 4'h8, 4'h1};
    logic         ov_exp[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, av[i], bv[i], 1'b0);
      check_result("overflow_sum");
      checks++;
      if (overflow !== ov_exp[i]) begin
        failures++;
        $display("[TB] FAIL overflow case %0d: overflow=%b, required %b", i, overflow, ov_exp[i]);
      end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overflow_hold: overflow=%b, required 0", overflow);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    test_reset();
    test_exhaustive();
    test_corners();
    test_hold();
    test_reset_midstream();
`ifdef RCA_OVERFLOW_EN
    test_overflow();
`endif
    checks++;
    if (scoreboard.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", scoreboard.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
